webp_mb_sequencer: RTL and testbench

//  Per-macroblock sequencer for the WebP encode path. It pops one macroblock from the input FIFOs and

---
 rtl/webp_mb_sequencer.sv | 121 ++++++++++++
 tb/tb_webp_mb_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/webp_mb_sequencer.sv
// Per-macroblock sequencer: pops one MB, kicks the decimate core, then serializes the
// captured result vector as NUM_BEATS backpressured beats while walking the MB raster.
module webp_mb_sequencer #(
  parameter int DATA_W    = 1024,
  parameter int NUM_BEATS = 7,
  parameter int POS_W     = 10
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic                        i_abort,
  input  logic [POS_W-1:0]            i_w1,
  input  logic [POS_W-1:0]            i_h1,
  input  logic                        i_in_fifo_empty,
  output logic                        o_in_fifo_rd,
  output logic                        o_core_start,
  input  logic                        i_core_done,
  input  logic [NUM_BEATS*DATA_W-1:0] i_core_result,
  output logic [POS_W-1:0]            o_mb_x,
  output logic [POS_W-1:0]            o_mb_y,
  input  logic                        i_out_fifo_full,
  output logic                        o_out_fifo_wr,
  output logic [DATA_W-1:0]           o_out_data,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_protocol_err
);
  localparam int CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RDEN, S_CSTART, S_WAIT, S_SEND, S_DONE
  } state_t;

  state_t                             r_state, w_state_nxt;
  logic [NUM_BEATS-1:0][DATA_W-1:0]   r_shadow;
  logic [CNT_W-1:0]                   r_beat;
  logic [POS_W-1:0]                   r_w1, r_h1, r_mb_x, r_mb_y;
  logic [DATA_W-1:0]                  r_out_data;
  logic                               r_perr;

  logic w_start_acc, w_pop, w_wr, w_last_beat, w_x_end, w_y_end, w_last_mb, w_capture;
  logic [CNT_W-1:0] w_beat_nxt;

  assign w_start_acc = (r_state == S_IDLE) & i_start;
  assign w_pop       = (r_state == S_RDEN) & ~i_in_fifo_empty;
  assign w_wr        = (r_state == S_SEND) & ~i_out_fifo_full;
  assign w_last_beat = (r_beat == CNT_W'(NUM_BEATS - 1));
  assign w_beat_nxt  = r_beat + 1'b1;
  assign w_x_end     = (r_mb_x >= r_w1);
  assign w_y_end     = (r_mb_y >= r_h1);
  assign w_last_mb   = w_x_end & w_y_end;
  assign w_capture   = (r_state == S_WAIT) & i_core_done & ~i_abort;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_state_nxt = S_RDEN;
      S_RDEN:   if (w_pop) w_state_nxt = S_CSTART;
      S_CSTART: w_state_nxt = S_WAIT;
      S_WAIT:   if (i_core_done) w_state_nxt = S_SEND;
      S_SEND:   if (w_wr && w_last_beat) w_state_nxt = w_last_mb ? S_DONE : S_RDEN;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    // abort overrides every other transition
    if (i_abort && r_state != S_IDLE) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow   <= '0;
      r_beat     <= '0;
      r_w1       <= '0;
      r_h1       <= '0;
      r_mb_x     <= '0;
      r_mb_y     <= '0;
      r_out_data <= '0;
      r_perr     <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_w1   <= i_w1;
        r_h1   <= i_h1;
        r_mb_x <= '0;
        r_mb_y <= '0;
      end
      // beat 0 is preloaded so it is on the bus in the first SEND cycle
      if (w_capture) begin
        r_shadow   <= i_core_result;
        r_beat     <= '0;
        r_out_data <= i_core_result[DATA_W-1:0];
      end
      if (w_wr && !i_abort) begin
        if (!w_last_beat) begin
          r_beat     <= w_beat_nxt;
          r_out_data <= r_shadow[w_beat_nxt];
        end else if (!w_last_mb) begin
          r_mb_x <= w_x_end ? '0 : r_mb_x + 1'b1;
          r_mb_y <= r_mb_y + {{(POS_W-1){1'b0}}, w_x_end};
        end
      end
      if (w_start_acc) r_perr <= 1'b0;
      if (i_core_done && r_state != S_WAIT) r_perr <= 1'b1;
    end
  end

  assign o_in_fifo_rd   = w_pop;
  assign o_core_start   = (r_state == S_CSTART);
  assign o_out_fifo_wr  = w_wr;
  assign o_out_data     = r_out_data;
  assign o_mb_x         = r_mb_x;
  assign o_mb_y         = r_mb_y;
  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = (r_state == S_DONE);
  assign o_protocol_err = r_perr;

endmodule

// File: tb/tb_webp_mb_sequencer.sv
// Directed bench for webp_mb_sequencer: raster walk, output backpressure, input starvation,
// abort/protocol error, start-while-busy and mid-frame async reset.
module tb_webp_mb_sequencer;
  localparam int DW = 8;
  localparam int NB = 3;
  localparam int PW = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0, abort = 1'b0;
  logic [PW-1:0]     w1 = '0, h1 = '0;
  logic              in_empty = 1'b0, out_full = 1'b0;
  logic              in_rd, core_start, core_done, out_wr, busy, done, perr;
  logic [NB*DW-1:0]  core_result;
  logic [PW-1:0]     mb_x, mb_y;
  logic [DW-1:0]     out_data;

  always #5 clk = ~clk;

  webp_mb_sequencer #(.DATA_W(DW), .NUM_BEATS(NB), .POS_W(PW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_w1(w1), .i_h1(h1), .i_in_fifo_empty(in_empty), .o_in_fifo_rd(in_rd),
    .o_core_start(core_start), .i_core_done(core_done), .i_core_result(core_result),
    .o_mb_x(mb_x), .o_mb_y(mb_y), .i_out_fifo_full(out_full), .o_out_fifo_wr(out_wr),
    .o_out_data(out_data), .o_busy(busy), .o_done(done), .o_protocol_err(perr)
  );

  typedef struct {
    logic [PW-1:0]    x;
    logic [PW-1:0]    y;
    logic [NB*DW-1:0] res;
  } mb_vec_t;
  mb_vec_t tbl[4];

  int checks = 0, errors = 0;
  int cyc = 0;
  int n_wr = 0, n_cs = 0, n_rd = 0, n_done = 0, viol = 0;
  int last_wr_cyc = 0, done_cyc = 0;
  logic [DW-1:0]    wr_q[$];
  int               wrc_q[$];
  logic [2*PW-1:0]  pos_q[$];
  logic [NB*DW-1:0] res_q[$];
  logic [NB*DW-1:0] def_res = 24'h332211;
  logic             core_auto = 1'b1, m_done = 1'b0, man_done = 1'b0;
  int               m_cnt = 0;

  assign core_done = m_done | man_done;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor
  always @(negedge clk) begin
    if (out_wr) begin
      n_wr++; wr_q.push_back(out_data); wrc_q.push_back(cyc); last_wr_cyc = cyc;
      if (out_full) viol++;
    end
    if (core_start) n_cs++;
    if (in_rd) n_rd++;
    if (done) begin n_done++; done_cyc = cyc; end
  end

  // Core model: done pulse 4 cycles after core_start, result chosen at start
  always @(negedge clk) begin
    m_done = 1'b0;
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) m_done = 1'b1;
    end
    if (core_auto && core_start) begin
      m_cnt = 4;
      pos_q.push_back({mb_x, mb_y});
      if (res_q.size() > 0) core_result = res_q.pop_front();
      else core_result = def_res;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk); #1;
  endtask

  task automatic start_frame(input logic [PW-1:0] w, input logic [PW-1:0] h);
    w1 = w; h1 = h; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n0 = n_done;
    int k = 0;
    while (n_done == n0 && k < budget) begin tick(); k++; end
    if (n_done == n0) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_mdone(input int budget);
    int k = 0;
    smp();
    while (!m_done && k < budget) begin tick(); smp(); k++; end
    if (!m_done) chk("core_done_timeout", 0, 1);
  endtask

  int s_wr, s_cs, s_rd, s_done;
  task automatic snap();
    s_wr = n_wr; s_cs = n_cs; s_rd = n_rd; s_done = n_done;
    wr_q.delete(); wrc_q.delete(); pos_q.delete();
  endtask

  initial begin
    core_result = '0;
    tbl[0] = '{x: 4'd0, y: 4'd0, res: 24'h302010};
    tbl[1] = '{x: 4'd1, y: 4'd0, res: 24'h615141};
    tbl[2] = '{x: 4'd0, y: 4'd1, res: 24'h928272};
    tbl[3] = '{x: 4'd1, y: 4'd1, res: 24'hC3B3A3};

    // Reset state
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_outs", {out_wr, in_rd, core_start, done, perr}, 0);
    chk("rst_pos", {mb_x, mb_y}, 0);
    chk("rst_data", out_data, 0);
    rst_n = 1'b1;
    tick();

    // 1: 2x2 raster, table-driven results and positions
    snap();
    for (int i = 0; i < 4; i++) res_q.push_back(tbl[i].res);
    start_frame(4'd1, 4'd1);
    wait_done(300);
    chk("t1_core_starts", n_cs - s_cs, 4);
    chk("t1_writes", n_wr - s_wr, 12);
    chk("t1_done_cnt", n_done - s_done, 1);
    chk("t1_done_lat", done_cyc, last_wr_cyc + 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_pos%0d", i), (pos_q.size() > i) ? pos_q[i] : 8'hFF, {tbl[i].x, tbl[i].y});
      for (int k = 0; k < NB; k++)
        chk($sformatf("t1_mb%0d_beat%0d", i, k),
            (wr_q.size() > i*NB+k) ? wr_q[i*NB+k] : 8'hxx, tbl[i].res[k*DW +: DW]);
    end
    chk("t1_final_pos", {mb_x, mb_y}, 8'h11);
    chk("t1_busy_after", busy, 0);

    // 2: output full for 5 cycles from first SEND cycle
    snap();
    res_q.push_back(24'hC0B0A0);
    start_frame(4'd0, 4'd0);
    wait_mdone(50);
    out_full = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick(); smp();
      chk($sformatf("t2_stall%0d", j), {out_wr, out_data}, {1'b0, 8'hA0});
    end
    tick();
    out_full = 1'b0;
    wait_done(50);
    chk("t2_writes", n_wr - s_wr, 3);
    chk("t2_data", {wr_q[0], wr_q[1], wr_q[2]}, 24'hA0B0C0);
    chk("t2_consec", (wrc_q[1] == wrc_q[0] + 1) && (wrc_q[2] == wrc_q[1] + 1), 1);
    chk("t2_no_wr_full", viol, 0);

    // 3: input FIFO empty for 10 cycles in RDEN
    snap();
    in_empty = 1'b1;
    start_frame(4'd0, 4'd0);
    for (int j = 0; j < 10; j++) tick();
    chk("t3_no_rd", n_rd - s_rd, 0);
    chk("t3_no_cs", n_cs - s_cs, 0);
    chk("t3_busy", busy, 1);
    in_empty = 1'b0;
    smp();
    chk("t3_rd_now", in_rd, 1);
    tick(); smp();
    chk("t3_cs_next", core_start, 1);
    wait_done(50);
    chk("t3_writes", n_wr - s_wr, 3);

    // 4: abort in WAIT, late core_done -> protocol error
    snap();
    core_auto = 1'b0;
    start_frame(4'd0, 4'd0);
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    tick(); tick();
    chk("t4_busy", busy, 0);
    chk("t4_perr", perr, 1);
    chk("t4_writes", n_wr - s_wr, 0);
    chk("t4_done", n_done - s_done, 0);
    core_auto = 1'b1;
    start_frame(4'd0, 4'd0);
    smp();
    chk("t4_perr_clr", perr, 0);
    wait_done(50);

    // 5: single MB, start during SEND ignored
    snap();
    start_frame(4'd0, 4'd0);
    wait_mdone(50);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(50);
    for (int j = 0; j < 5; j++) tick();
    chk("t5_writes", n_wr - s_wr, 3);
    chk("t5_done", n_done - s_done, 1);
    chk("t5_no_restart", {busy, 32'(n_rd - s_rd)}, {1'b0, 32'd1});

    // 6: async reset during SEND beat 1
    snap();
    start_frame(4'd0, 4'd0);
    wait_mdone(50);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("t6_outs", {out_wr, in_rd, core_start, done, perr, busy}, 0);
    chk("t6_data", out_data, 0);
    chk("t6_pos", {mb_x, mb_y}, 0);
    s_wr = n_wr;
    tick(); tick();
    rst_n = 1'b1;
    for (int j = 0; j < 10; j++) tick();
    chk("t6_no_wr", n_wr - s_wr, 0);
    chk("t6_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
